// File: rtl/time_pkg.sv
// Shared definitions for the keypad time-entry path: widths, FSM encoding and
// the 24-hour clock digit limits.
package time_pkg;

    localparam int unsigned DWL_DEF       = 8;
    localparam int unsigned DIGIT_W_DEF   = DWL_DEF - 4;
    localparam int unsigned HOURS_W_DEF   = DWL_DEF - 3;
    localparam int unsigned MINUTES_W_DEF = DWL_DEF - 2;

    // S_HT..S_MO encode the digit index directly so entry_pos is the low state bits.
    typedef enum logic [2:0] {
        S_HT     = 3'd0,
        S_HO     = 3'd1,
        S_MT     = 3'd2,
        S_MO     = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    localparam int unsigned MAX_HT       = 2;
    localparam int unsigned MAX_HO_AT_20 = 3;
    localparam int unsigned MAX_MT       = 5;
    localparam int unsigned MAX_DIGIT    = 9;

    // Whether digit d may be taken in state st, given the hours tens already held.
    function automatic logic digit_ok(input state_t st, input int unsigned d,
                                      input int unsigned ht);
        logic ok;
        ok = 1'b0;
        case (st)
            S_HT: ok = (d <= MAX_HT);
            S_HO: begin
                if (ht == MAX_HT) ok = (d <= MAX_HO_AT_20);
                else              ok = (d <= MAX_DIGIT);
            end
            S_MT: ok = (d <= MAX_MT);
            S_MO: ok = (d <= MAX_DIGIT);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/bcd2_to_bin.sv
// Two BCD digits to binary: tens*10 + ones, built from shifts and adds only.
module bcd2_to_bin #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned OUT_W   = 5
) (
    input  logic [DIGIT_W-1:0] tens,
    input  logic [DIGIT_W-1:0] ones,
    output logic [OUT_W-1:0]   value
);

    logic [OUT_W-1:0] tens_ext;
    logic [OUT_W-1:0] ones_ext;

    always_comb begin
        tens_ext = OUT_W'(tens);
        ones_ext = OUT_W'(ones);
        // Sum wraps at OUT_W; legal clock digits never reach the wrap.
        value    = (tens_ext << 3) + (tens_ext << 1) + ones_ext;
    end

endmodule

// File: rtl/time_digit_entry.sv
// Collects HH:MM as four BCD keypresses, validates each against 24-hour limits
// and presents the assembled binary time with a one-cycle load pulse.
module time_digit_entry
    import time_pkg::*;
#(
    parameter int unsigned DWL = DWL_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           digit_valid,
    input  logic [DWL-5:0] digit,
    input  logic           cancel,
    output logic [DWL-4:0] Hours,
    output logic [DWL-3:0] Minutes,
    output logic           load,
    output logic           digit_err,
    output logic [1:0]     entry_pos,
    output logic           busy
);

    localparam int unsigned DW = DWL - 4;
    localparam int unsigned HW = DWL - 3;
    localparam int unsigned MW = DWL - 2;

    state_t        state;
    logic [DW-1:0] ht, ho, mt, mo;
    logic [HW-1:0] hours_bin;
    logic [MW-1:0] minutes_bin;
    logic          digit_accept;

    bcd2_to_bin #(
        .DIGIT_W (DW),
        .OUT_W   (HW)
    ) u_hours_conv (
        .tens  (ht),
        .ones  (ho),
        .value (hours_bin)
    );

    bcd2_to_bin #(
        .DIGIT_W (DW),
        .OUT_W   (MW)
    ) u_minutes_conv (
        .tens  (mt),
        .ones  (mo),
        .value (minutes_bin)
    );

    assign digit_accept = digit_ok(state, 32'(digit), 32'(ht));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_HT;
            ht        <= '0;
            ho        <= '0;
            mt        <= '0;
            mo        <= '0;
            Hours     <= '0;
            Minutes   <= '0;
            load      <= 1'b0;
            digit_err <= 1'b0;
        end else begin
            load      <= 1'b0;
            digit_err <= 1'b0;
            // The commit cycle wins over cancel and ignores any offered digit.
            if (state == S_COMMIT) begin
                Hours   <= hours_bin;
                Minutes <= minutes_bin;
                load    <= 1'b1;
                state   <= S_HT;
            end else if (cancel) begin
                state <= S_HT;
                ht    <= '0;
                ho    <= '0;
                mt    <= '0;
                mo    <= '0;
            end else if (digit_valid) begin
                if (digit_accept) begin
                    case (state)
                        S_HT: begin
                            ht    <= digit;
                            state <= S_HO;
                        end
                        S_HO: begin
                            ho    <= digit;
                            state <= S_MT;
                        end
                        S_MT: begin
                            mt    <= digit;
                            state <= S_MO;
                        end
                        S_MO: begin
                            mo    <= digit;
                            state <= S_COMMIT;
                        end
                        default: state <= S_HT;
                    endcase
                end else begin
                    digit_err <= 1'b1;
                end
            end
        end
    end

    assign entry_pos = (state == S_COMMIT) ? 2'd0 : state[1:0];
    assign busy      = (entry_pos != 2'd0);

endmodule

// File: tb/tb_time_digit_entry.sv
// Directed and randomised keypad entry against a behavioural HH:MM model.
module tb_time_digit_entry;

    logic       clk = 1'b0;
    logic       reset;
    logic       digit_valid;
    logic [3:0] digit;
    logic       cancel;
    logic [4:0] Hours;
    logic [5:0] Minutes;
    logic       load;
    logic       digit_err;
    logic [1:0] entry_pos;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: position 0..3 is the next digit, 4 means a complete time awaits commit.
    int m_pos;
    int m_d [4];
    int m_hours, m_minutes;
    bit m_load, m_err;

    always #5 clk = ~clk;

    time_digit_entry #(.DWL(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_valid (digit_valid),
        .digit       (digit),
        .cancel      (cancel),
        .Hours       (Hours),
        .Minutes     (Minutes),
        .load        (load),
        .digit_err   (digit_err),
        .entry_pos   (entry_pos),
        .busy        (busy)
    );

    // A digit is acceptable if it is BCD and some completion still keeps HH<=23, MM<=59.
    function automatic bit legal(input int p, input int d);
        if (d > 9) return 1'b0;
        case (p)
            0: return (d * 10 <= 23);
            1: return (m_d[0] * 10 + d <= 23);
            2: return (d * 10 <= 59);
            3: return (m_d[2] * 10 + d <= 59);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clock(input bit v, input int d, input bit c, input bit r);
        if (r) begin
            m_pos = 0;
            for (int i = 0; i < 4; i++) m_d[i] = 0;
            m_hours = 0; m_minutes = 0; m_load = 0; m_err = 0;
        end else begin
            m_load = 0;
            m_err  = 0;
            if (m_pos == 4) begin
                m_hours   = m_d[0] * 10 + m_d[1];
                m_minutes = m_d[2] * 10 + m_d[3];
                m_load    = 1;
                m_pos     = 0;
            end else if (c) begin
                m_pos = 0;
                for (int i = 0; i < 4; i++) m_d[i] = 0;
            end else if (v) begin
                if (legal(m_pos, d)) begin
                    m_d[m_pos] = d;
                    m_pos++;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int ep;
        ep = (m_pos == 4) ? 0 : m_pos;
        chk("hours",     32'(Hours),     32'(m_hours));
        chk("minutes",   32'(Minutes),   32'(m_minutes));
        chk("load",      32'(load),      32'(m_load));
        chk("digit_err", 32'(digit_err), 32'(m_err));
        chk("entry_pos", 32'(entry_pos), 32'(ep));
        chk("busy",      32'(busy),      32'(ep != 0));
        chk("excl",      32'(load & digit_err), 32'(0));
    endtask

    task automatic step(input bit v, input int d, input bit c, input bit r);
        @(negedge clk);
        digit_valid = v;
        digit       = 4'(d);
        cancel      = c;
        reset       = r;
        @(posedge clk);
        #1;
        model_clock(v, d, c, r);
        check_model();
    endtask

    task automatic key(input int d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        bit v, c, r;
        int d;
        reset = 1'b1; digit_valid = 1'b0; digit = '0; cancel = 1'b0;
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_pos = 0; m_hours = 0; m_minutes = 0; m_load = 0; m_err = 0;

        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_hours", 32'(Hours), 0);
        chk("rst_pos",   32'(entry_pos), 0);
        chk("rst_busy",  32'(busy), 0);

        // 17:45 with idle gaps
        key(1); idle(); key(7); idle(); key(4); idle(); key(5);
        chk("t1_busy_off", 32'(busy), 0);
        idle();
        chk("t1_load",    32'(load), 1);
        chk("t1_hours",   32'(Hours), 17);
        chk("t1_minutes", 32'(Minutes), 45);
        idle();
        chk("t1_load_off", 32'(load), 0);

        // 24 rejected at hours ones, then 23:59
        key(2); key(4);
        chk("t2_err", 32'(digit_err), 1);
        chk("t2_pos", 32'(entry_pos), 1);
        key(3); key(5); key(9); idle();
        chk("t2_load",    32'(load), 1);
        chk("t2_hours",   32'(Hours), 23);
        chk("t2_minutes", 32'(Minutes), 59);

        // Rejection at each position
        key(3);
        chk("t3_err0", 32'(digit_err), 1);
        chk("t3_pos0", 32'(entry_pos), 0);
        key(1); key(2); key(6);
        chk("t3_err2", 32'(digit_err), 1);
        chk("t3_pos2", 32'(entry_pos), 2);
        key(3); key(10);
        chk("t3_err3", 32'(digit_err), 1);
        chk("t3_pos3", 32'(entry_pos), 3);
        chk("t3_hours", 32'(Hours), 23);
        chk("t3_minutes", 32'(Minutes), 59);
        step(0, 0, 1, 0);

        // Cancel mid-entry, then 00:00
        key(0); key(9); key(3); step(0, 0, 1, 0);
        chk("t4_pos",  32'(entry_pos), 0);
        chk("t4_busy", 32'(busy), 0);
        idle();
        chk("t4_noload", 32'(load), 0);
        key(0); key(0); key(0); key(0); idle();
        chk("t4_load",    32'(load), 1);
        chk("t4_hours",   32'(Hours), 0);
        chk("t4_minutes", 32'(Minutes), 0);

        // Cancel together with the last digit suppresses the commit
        key(1); key(2); key(3); step(1, 4, 1, 0);
        chk("t5_pos", 32'(entry_pos), 0);
        idle();
        chk("t5_noload", 32'(load), 0);
        chk("t5_hours",  32'(Hours), 0);

        // Cancel during the commit cycle does not stop it
        key(1); key(2); key(3); key(4); step(0, 0, 1, 0);
        chk("t6_load",    32'(load), 1);
        chk("t6_hours",   32'(Hours), 12);
        chk("t6_minutes", 32'(Minutes), 34);

        // Reset mid-entry, overriding a simultaneous digit and cancel
        key(1); key(2); step(1, 3, 1, 1);
        chk("t7_hours", 32'(Hours), 0);
        chk("t7_pos",   32'(entry_pos), 0);
        key(3);
        chk("t7_restart_err", 32'(digit_err), 1);
        key(1);
        chk("t7_restart_pos", 32'(entry_pos), 1);

        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 9) < 7) d = $urandom_range(0, 9);
            else                          d = $urandom_range(0, 15);
            c = ($urandom_range(0, 29) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(v, d, c, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/time_digit_entry.md
Name: time_digit_entry

Overview:
- Reverse of the clock's binary-to-digit split: accepts four BCD digits one at a time (HH:MM, most significant first), validates each against 24-hour clock limits, then assembles binary Hours and Minutes.
- Presents the assembled values with a one-cycle load pulse so the time-keeping counter can be preset from button or keypad entry.
- Sits between the input debouncer/keypad decoder and the hours/minutes counters.

Parameters:
- DWL, 8, base data word length. Digit width is DWL-4 (4), Hours width is DWL-3 (5), Minutes width is DWL-2 (6). Same width derivation as the display path.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous active-high reset.
- digit_valid, input, 1, a digit is offered this cycle (single-cycle strobe per keypress).
- digit, input, DWL-4, BCD digit value 0..15; values above 9 are always invalid.
- cancel, input, 1, abort current entry.
- Hours, output, DWL-3, last committed binary hours 0..23, registered.
- Minutes, output, DWL-2, last committed binary minutes 0..59, registered.
- load, output, 1, one-cycle pulse when Hours/Minutes take a new committed value.
- digit_err, output, 1, one-cycle pulse when an offered digit is rejected.
- entry_pos, output, 2, index of the digit expected next: 0=H tens, 1=H ones, 2=M tens, 3=M ones.
- busy, output, 1, high while at least one digit of the current entry is accepted (entry_pos != 0).

Behaviour:
- Reset values (synchronous, takes effect on the next clk edge while reset=1):
  - Hours=0, Minutes=0, load=0, digit_err=0, entry_pos=0, busy=0.
  - Internal digit registers ht, ho, mt, mo = 0.
- FSM states: S_HT, S_HO, S_MT, S_MO, S_COMMIT. Reset state is S_HT. entry_pos is the state encoding for S_HT..S_MO; it reads 0 in S_COMMIT.
- Acceptance rules, evaluated only when digit_valid=1 and cancel=0:
  - S_HT: accept 0..2. Store ht, go to S_HO.
  - S_HO: if ht=2, accept 0..3; else accept 0..9. Store ho, go to S_MT.
  - S_MT: accept 0..5. Store mt, go to S_MO.
  - S_MO: accept 0..9. Store mo, go to S_COMMIT.
  - On rejection: digit_err=1 for exactly the next cycle; state and stored digits unchanged.
- S_COMMIT lasts exactly one cycle and always returns to S_HT:
  - Hours <= ht*10 + ho; Minutes <= mt*10 + mo.
  - The multiply-by-10 is implemented as (x<<3)+(x<<1). No multiplier inference. Intermediate sums are truncated to the output width; legal ranges cannot overflow.
  - load is registered with Hours/Minutes: it is high in the cycle the new values first appear.
- Latency: the final digit is strobed at edge N; state = S_COMMIT after edge N; Hours/Minutes/load update at edge N+1.
- digit_valid while in S_COMMIT is ignored: no error, no capture.
- cancel=1:
  - Returns to S_HT at the next edge and clears ht, ho, mt, mo.
  - Hours/Minutes hold their previous values; no load, no digit_err.
  - cancel takes priority over a simultaneous digit_valid, including in S_MO (no commit).
  - cancel in S_COMMIT does not suppress that commit.
- Reset mid-entry discards partial digits, and reset overrides both cancel and digit_valid.
- Hours and Minutes change only on a commit or on reset.
- digit_err and load are never high in the same cycle.

Decomposition:
- Shared package (time_pkg):
  - State encoding localparams S_HT..S_COMMIT.
  - Limits: MAX_HT=2, MAX_HO_AT_20=3, MAX_MT=5, MAX_DIGIT=9.
  - Width constants derived from DWL.
- One sub-module: bcd2_to_bin. Purely combinational; takes tens and ones digits and returns tens*10+ones using the shift-add form. Instantiated twice, once for hours and once for minutes.

Test Plan:
- Reset then strobe digits 1,7,4,5 (one idle cycle between each) -> after the 4th strobe, busy deasserts; one cycle later load=1 for one cycle with Hours=17 (5'b10001) and Minutes=45 (6'b101101).
- Entry 2,4 -> digit_err pulses on the 4 with entry_pos staying 1. Continue 3,5,9 -> load with Hours=23, Minutes=59.
- Rejection at each position:
  - First digit 3 -> digit_err, entry_pos=0.
  - Minute tens 6 -> digit_err, entry_pos=2.
  - digit=4'hA at minute ones -> digit_err, entry_pos=3.
  - In all three cases Hours/Minutes are unchanged.
- Enter 0,9,3 then cancel -> entry_pos=0, busy=0, no load. Then enter 0,0,0,0 -> Hours=0, Minutes=0, load=1.
- Assert cancel and digit_valid together with the 4th digit -> no load, entry_pos=0. Separately, assert reset after the 2nd digit -> all outputs return to reset values, and the next entry starts at H tens.
